// File: rtl/fc3_pkg.sv
// Shared constants and state encoding for the fc3 unary receive datapath.
package fc3_pkg;

  localparam int RWID = 10;
  localparam int WLEN = 1 << RWID;
  localparam int CWID = RWID + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/fc3_unary_counter.sv
// Per-channel ones counter: synchronous clear at window open, +1 on each counted one.
module fc3_unary_counter #(
  parameter int CWID = fc3_pkg::CWID
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            inc,
  output logic [CWID-1:0] cnt
);

  // Accumulator register; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/fc3_unary_count_array.sv
// Decodes NCH unary bitstreams to binary counts over a window of 2^RWID enabled
// cycles, with a single-entry valid/ready output register.
module fc3_unary_count_array #(
  parameter  int RWID = fc3_pkg::RWID,
  parameter  int NCH  = 1024,
  localparam int CWID = RWID + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            enable,
  input  logic [NCH-1:0]  bitIn,
  output logic            accReady,
  output logic            busy,
  output logic            outValid,
  input  logic            outReady,
  output logic [CWID-1:0] cntOut [NCH]
);

  import fc3_pkg::*;

  localparam int WLEN = 1 << RWID;

  state_t          state;
  logic [RWID-1:0] cyc_cnt;
  logic [CWID-1:0] acc [NCH];
  logic            clr;
  logic            inc;
  logic            last_bit;
  logic            xfer;
  logic            load;

  // Load happens at window end when the output slot is free or draining, or from HOLD on transfer.
  always_comb begin
    clr      = (state == IDLE) && start;
    inc      = (state == ACC) && enable;
    last_bit = inc && (cyc_cnt == RWID'(WLEN - 1));
    xfer     = outValid && outReady;
    load     = (last_bit && (!outValid || xfer)) || ((state == HOLD) && xfer);
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    fc3_unary_counter #(
      .CWID(CWID)
    ) u_cnt (
      .clk(clk),
      .rst(rst),
      .clr(clr),
      .inc(inc & bitIn[g]),
      .cnt(acc[g])
    );
  end

  // Window FSM with registered status outputs and the output-valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cyc_cnt  <= '0;
      busy     <= 1'b0;
      accReady <= 1'b1;
      outValid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ACC;
            cyc_cnt  <= '0;
            busy     <= 1'b1;
            accReady <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        ACC: begin
          if (inc) begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt;
          end
          if (last_bit && load) begin
            state    <= IDLE;
            busy     <= 1'b0;
            accReady <= 1'b1;
          end else if (last_bit) begin
            state    <= HOLD;
            busy     <= 1'b1;
            accReady <= 1'b0;
          end else begin
            state <= ACC;
          end
        end
        HOLD: begin
          if (xfer) begin
            state    <= IDLE;
            busy     <= 1'b0;
            accReady <= 1'b1;
          end else begin
            state <= HOLD;
          end
        end
        default: begin
          state    <= IDLE;
          cyc_cnt  <= '0;
          busy     <= 1'b0;
          accReady <= 1'b1;
        end
      endcase

      if (load) begin
        outValid <= 1'b1;
      end else if (xfer) begin
        outValid <= 1'b0;
      end else begin
        outValid <= outValid;
      end
    end
  end

  // Output register; at window end the final bit is folded in since acc has not yet seen it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        cntOut[i] <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < NCH; i++) begin
        cntOut[i] <= acc[i] + {{(CWID-1){1'b0}}, inc & bitIn[i]};
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cntOut[i] <= cntOut[i];
      end
    end
  end

endmodule

// File: tb/tb_fc3_unary_count_array.sv
// Directed self-checking bench for fc3_unary_count_array at default sizes.
module tb_fc3_unary_count_array;

  localparam int RWID = 10;
  localparam int NCH  = 1024;
  localparam int CWID = RWID + 1;
  localparam int WLEN = 1024;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            enable = 1'b0;
  logic [NCH-1:0]  bit_in = '0;
  logic            out_ready = 1'b0;
  logic            acc_ready;
  logic            busy;
  logic            out_valid;
  logic [CWID-1:0] cnt_out [NCH];

  int errors = 0;
  int checks = 0;

  fc3_unary_count_array #(.RWID(RWID), .NCH(NCH)) dut (
    .clk(clk), .rst(rst), .start(start), .enable(enable), .bitIn(bit_in),
    .accReady(acc_ready), .busy(busy), .outValid(out_valid),
    .outReady(out_ready), .cntOut(cnt_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: all ones; 1: even ch alternate 1/0, odd ch 0; 2: odd ch ones; 3: ch0 first 300; else zeros
  function automatic logic [NCH-1:0] pattern(input int mode, input int k);
    logic [NCH-1:0] v;
    v = '0;
    for (int c = 0; c < NCH; c++) begin
      case (mode)
        0: v[c] = 1'b1;
        1: v[c] = (c % 2 == 0) && (k % 2 == 0);
        2: v[c] = (c % 2 == 1);
        3: v[c] = (c == 0) && (k < 300);
        default: v[c] = 1'b0;
      endcase
    end
    return v;
  endfunction

  function automatic int expect_cnt(input int mode, input int c);
    case (mode)
      0: return 1024;
      1: return (c % 2 == 0) ? 512 : 0;
      2: return (c % 2 == 1) ? 1024 : 0;
      3: return (c == 0) ? 300 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic int count_bad(input int mode);
    int bad;
    logic [CWID-1:0] e;
    bad = 0;
    for (int c = 0; c < NCH; c++) begin
      e = CWID'(expect_cnt(mode, c));
      if (cnt_out[c] !== e) bad++;
    end
    return bad;
  endfunction

  // Opens a window and feeds bits until WLEN enabled cycles have passed (bounded).
  task automatic run_window(input int mode, input bit gaps, input int start_at,
                            input bit ready_at_end, output int cycles, output bit early);
    int enabled;
    start = 1'b1;
    enable = 1'b0;
    step();
    start = 1'b0;
    enabled = 0;
    cycles = 0;
    early = 1'b0;
    while (enabled < WLEN && cycles < 4 * WLEN) begin
      enable = gaps ? (cycles % 3 != 0) : 1'b1;
      bit_in = pattern(mode, enabled);
      start = (cycles == start_at);
      if (enable && enabled == WLEN - 1) out_ready = ready_at_end;
      step();
      if (enable) enabled++;
      cycles++;
      if (enabled < WLEN && busy !== 1'b1) early = 1'b1;
    end
    start = 1'b0;
    enable = 1'b0;
    bit_in = '1;
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (acc_ready !== 1'b1) begin errors++; $display("FAIL reset_acc_ready: got %0b expected 1", acc_ready); end
    bad = count_bad(4);
    checks++; if (bad !== 0) begin errors++; $display("FAIL reset_counts: %0d channels nonzero, ch0=%0d expected 0", bad, cnt_out[0]); end
  endtask

  task automatic test_all_ones();
    int cyc;
    bit early;
    int bad;
    out_ready = 1'b1;
    run_window(0, 1'b0, -1, 1'b1, cyc, early);
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL ones_early_end: got early=%0b expected 0", early); end
    checks++; if (cyc !== 1024) begin errors++; $display("FAIL ones_cycles: got %0d expected 1024", cyc); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ones_out_valid: got %0b expected 1", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ones_busy: got %0b expected 0", busy); end
    bad = count_bad(0);
    checks++; if (bad !== 0) begin errors++; $display("FAIL ones_counts: %0d bad channels, ch0=%0d expected 1024", bad, cnt_out[0]); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ones_valid_clear: got %0b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit early;
    int bad;
    out_ready = 1'b1;
    for (int w = 0; w < 2; w++) begin
      run_window(1, 1'b0, -1, 1'b1, cyc, early);
      bad = count_bad(1);
      checks++; if (bad !== 0) begin errors++; $display("FAIL alt_counts_w%0d: %0d bad, ch0=%0d ch1=%0d expected 512/0", w, bad, cnt_out[0], cnt_out[1]); end
      checks++; if (out_valid !== 1'b1 || cyc !== 1024) begin errors++; $display("FAIL alt_end_w%0d: valid=%0b cycles=%0d expected 1/1024", w, out_valid, cyc); end
    end
  endtask

  task automatic test_enable_gaps();
    int cyc;
    bit early;
    int bad;
    out_ready = 1'b1;
    run_window(0, 1'b1, -1, 1'b1, cyc, early);
    checks++; if (cyc !== 1536 || early !== 1'b0) begin errors++; $display("FAIL gaps_cycles: got %0d early=%0b expected 1536 early=0", cyc, early); end
    bad = count_bad(0);
    checks++; if (bad !== 0) begin errors++; $display("FAIL gaps_counts: %0d bad, ch0=%0d expected 1024", bad, cnt_out[0]); end
  endtask

  task automatic test_start_ignored();
    int cyc;
    bit early;
    int bad;
    out_ready = 1'b1;
    run_window(3, 1'b0, 100, 1'b1, cyc, early);
    checks++; if (cyc !== 1024 || early !== 1'b0) begin errors++; $display("FAIL start_ign_cycles: got %0d early=%0b expected 1024 early=0", cyc, early); end
    bad = count_bad(3);
    checks++; if (bad !== 0) begin errors++; $display("FAIL start_ign_counts: %0d bad, ch0=%0d expected 300", bad, cnt_out[0]); end
  endtask

  task automatic test_backpressure();
    int cyc;
    bit early;
    int bad;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    run_window(0, 1'b0, -1, 1'b0, cyc, early);
    checks++; if (out_valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL bp_first_end: valid=%0b busy=%0b expected 1/0", out_valid, busy); end
    run_window(2, 1'b0, -1, 1'b0, cyc, early);
    checks++; if (busy !== 1'b1 || acc_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold: busy=%0b acc_ready=%0b valid=%0b expected 1/0/1", busy, acc_ready, out_valid); end
    enable = 1'b1;
    bit_in = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    enable = 1'b0;
    bad = count_bad(0);
    checks++; if (bad !== 0 || busy !== 1'b1 || acc_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_stable: %0d bad, ch1=%0d busy=%0b acc_ready=%0b expected 0 bad/1024/1/0", bad, cnt_out[1], busy, acc_ready); end
    out_ready = 1'b1;
    step();
    bad = count_bad(2);
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_reload_counts: %0d bad, ch0=%0d ch1=%0d expected 0/1024", bad, cnt_out[0], cnt_out[1]); end
    checks++; if (out_valid !== 1'b1 || busy !== 1'b0 || acc_ready !== 1'b1) begin errors++; $display("FAIL bp_release: valid=%0b busy=%0b acc_ready=%0b expected 1/0/1", out_valid, busy, acc_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %0b expected 0", out_valid); end
  endtask

  task automatic test_mid_reset();
    int cyc;
    bit early;
    int bad;
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    enable = 1'b1;
    bit_in = '1;
    for (int k = 0; k < 500; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    enable = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || acc_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_state: valid=%0b busy=%0b acc_ready=%0b expected 0/0/1", out_valid, busy, acc_ready); end
    bad = count_bad(4);
    checks++; if (bad !== 0) begin errors++; $display("FAIL rst_mid_counts: %0d nonzero, ch1=%0d expected 0", bad, cnt_out[1]); end
    run_window(0, 1'b0, -1, 1'b1, cyc, early);
    bad = count_bad(0);
    checks++; if (bad !== 0 || cyc !== 1024) begin errors++; $display("FAIL rst_after_window: %0d bad, ch0=%0d cycles=%0d expected 1024/1024", bad, cnt_out[0], cyc); end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_back_to_back();
    test_enable_gaps();
    test_start_ignored();
    test_backpressure();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fc3_unary_count_array.md
Name: fc3_unary_count_array

Overview:
- Receive end of the fc3 unary datapath: decodes NCH parallel unary bitstreams back to binary by counting ones over a window of 2^RWID valid cycles.
- Bitstreams are produced upstream by comparators fed by the fc3 Sobol RNG share array.
- Results go to a single-entry output register with a valid/ready handshake, so the next window can accumulate while the previous result waits.

Parameters:
RWID, 10, rng width; window length WLEN = 2^RWID valid cycles
NCH, 1024, number of parallel bitstream channels (32 buffers x 32 sharing)
CWID, RWID+1, count width; holds 0..WLEN inclusive

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
start  input  1  single-cycle pulse; opens a window (honoured only in IDLE)
enable  input  1  qualifies bitIn this cycle; gates the shared RNG upstream
bitIn  input  NCH  one unary bit per channel
accReady  output  1  high in IDLE and ACC (bits accepted); low in HOLD
busy  output  1  high in ACC or HOLD
outValid  output  1  output register holds an unconsumed result
outReady  input  1  consumer accepts result
cntOut  output  [CWID-1:0] x NCH (unpacked array)  decoded counts

Behaviour:
- Reset: state IDLE; all accumulators, cycCnt, and the cntOut register = 0; outValid = 0; busy = 0; accReady = 1.
- Reset asserted mid-window or during HOLD discards the partial or pending result. outValid drops on the next edge.
- State IDLE:
  - start=1 -> ACC next cycle; accumulators and cycCnt cleared.
  - Bits present in the start cycle are NOT counted.
- State ACC:
  - enable=1: acc[i] += bitIn[i] for each channel; cycCnt += 1.
  - enable=0: nothing changes.
  - start is ignored.
  - Last bit: enable=1 with cycCnt == WLEN-1. That bit is included in the final count.
- Window end (the edge after the last bit):
  - Output register free, or freeing (outValid=0, or outValid&&outReady that same cycle) -> cntOut <= final acc; outValid=1; state -> IDLE.
  - Otherwise -> HOLD with final acc retained.
- Latency: outValid rises on the edge after the last counted bit, with no backpressure.
- State HOLD:
  - accReady=0; bitIn, enable and start are ignored.
  - When outValid&&outReady: cntOut <= acc, outValid stays 1, state -> IDLE.
- Output handshake:
  - Transfer occurs when outValid&&outReady.
  - cntOut is stable while outValid=1 and outReady=0.
  - outValid clears after a transfer unless reloaded in the same cycle.
- Simultaneous events: window end plus transfer in the same cycle reloads directly, with no HOLD and no bubble.
- Arithmetic: accumulators are unsigned CWID bits and cannot overflow (max WLEN). cycCnt is RWID bits and wraps to 0 at window end.
- Bipolar interpretation (2*cnt - WLEN) is the consumer's job and is not done here.

Decomposition:
- Shared package fc3_pkg holds RWID, WLEN, CWID and the state enum (IDLE, ACC, HOLD).
- One natural sub-module: fc3_unary_counter. It is a per-channel CWID accumulator with clear/inc and is instantiated NCH times in a generate loop.
- The top level owns the FSM, cycCnt and the output register.

Test Plan:
- All-ones, enable held high, outReady=1: start, 1024 cycles bitIn all ones -> outValid one cycle after the 1024th bit; every cntOut = 1024; busy low the same cycle.
- Alternating 1/0 on even channels and all-zero on odd channels -> even channels read 512, odd read 0. A second window started immediately reproduces the same values.
- enable low 1 of every 3 cycles with bits=1 during the low cycles -> counts still 1024. Window closes after exactly 1024 enabled cycles (1536 total).
- Backpressure: outReady=0 with a prior result pending when the window ends -> HOLD; accReady=0; cntOut holds the old value. Raising outReady transfers the old result, loads the new result the next cycle, and the FSM returns to IDLE.
- start pulsed mid-ACC and during HOLD -> ignored. Window length and counts are unchanged (channel 0 with 300 ones reads 300).
- rst asserted at cycle 500 of a window -> next edge: all counts 0, outValid=0, IDLE. A following full window of ones reads 1024 with no residue.
